// File: rtl/div_frontend.sv
// div_frontend: sequences RV32M divide/remainder requests onto a multi-cycle radix-2 divider.
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   valid, op, rs1, rs2   request (op is DIV/DIVU/REM/REMU), sampled in IDLE
//   flush                 abandon the current request and clear the cache
//   ready, result         one-cycle completion pulse and the selected quotient/remainder
//   div_zero              divisor was zero (meaningful while ready is high)
//   div_valid, div_op,    launch pulse and operands towards the divider
//   div_a, div_b
//   div_ready, div_result divider completion pulse and result (combinational on div_op)
`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`define DIV_OP_DIV  2'b00
`define DIV_OP_DIVU 2'b01
`define DIV_OP_REM  2'b10
`define DIV_OP_REMU 2'b11
`endif

module div_frontend #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     valid,
  input  logic [`DIV_OP_WIDTH-1:0] op,
  input  logic [31:0]              rs1,
  input  logic [31:0]              rs2,
  input  logic                     flush,
  output logic                     ready,
  output logic [31:0]              result,
  output logic                     div_zero,
  output logic                     div_valid,
  output logic [`DIV_OP_WIDTH-1:0] div_op,
  output logic [31:0]              div_a,
  output logic [31:0]              div_b,
  input  logic                     div_ready,
  input  logic [31:0]              div_result
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CAPR   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  logic [2:0]               state;
  logic [`DIV_OP_WIDTH-1:0] op_q;
  logic [31:0]              q, c_a, c_b, c_q, c_r;
  logic                     c_sgn, cache_valid;
  logic                     sgn_in, is_q_in, hit, zero, ovf;
  // op[0] selects unsigned, op[1] selects remainder
  assign sgn_in  = ~op[0];
  assign is_q_in = ~op[1];
  assign hit     = CACHE_EN && cache_valid && rs1 == c_a && rs2 == c_b && sgn_in == c_sgn;
  assign zero    = rs2 == 32'd0;
  assign ovf     = sgn_in && rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF;
  assign ready   = state == S_DONE && !flush;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      result      <= '0;
      div_zero    <= 1'b0;
      div_valid   <= 1'b0;
      div_op      <= `DIV_OP_DIV;
      div_a       <= '0;
      div_b       <= '0;
      op_q        <= `DIV_OP_DIV;
      q           <= '0;
      cache_valid <= 1'b0;
      c_a         <= '0;
      c_b         <= '0;
      c_q         <= '0;
      c_r         <= '0;
      c_sgn       <= 1'b0;
    end else if (flush) begin
      cache_valid <= 1'b0;
      div_valid   <= 1'b0;
      // a launched divide cannot be aborted: wait out its div_ready unless it is arriving now
      state <= (state == S_LAUNCH || ((state == S_WAIT || state == S_DRAIN) && !div_ready))
               ? S_DRAIN : S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (valid) begin
          op_q     <= op;
          div_zero <= !hit && zero;
          state    <= (hit || zero || ovf) ? S_DONE : S_LAUNCH;
          if (hit) result <= is_q_in ? c_q : c_r;
          else if (zero) result <= is_q_in ? 32'hFFFF_FFFF : rs1;
          else if (ovf) result <= is_q_in ? 32'h8000_0000 : 32'd0;
          else begin
            div_a     <= rs1;
            div_b     <= rs2;
            div_op    <= {1'b0, op[0]};
            div_valid <= 1'b1;
          end
        end
        S_LAUNCH: begin
          div_valid <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: if (div_ready) begin
          q      <= div_result;
          div_op <= {1'b1, op_q[0]};
          state  <= S_CAPR;
        end
        S_CAPR: begin
          c_a         <= div_a;
          c_b         <= div_b;
          c_sgn       <= ~op_q[0];
          c_q         <= q;
          c_r         <= div_result;
          cache_valid <= 1'b1;
          result      <= op_q[1] ? div_result : q;
          state       <= S_DONE;
        end
        S_DRAIN: if (div_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_frontend.sv
// tb_div_frontend: directed scoreboard bench for div_frontend with a behavioural 32-step divider.
`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`define DIV_OP_DIV  2'b00
`define DIV_OP_DIVU 2'b01
`define DIV_OP_REM  2'b10
`define DIV_OP_REMU 2'b11
`endif

module tb_div_frontend;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic valid = 1'b0;
  logic [1:0] op = `DIV_OP_DIV;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic flush = 1'b0;
  logic ready, div_zero, div_valid, div_ready;
  logic [1:0] div_op;
  logic [31:0] result, div_a, div_b, div_result;
  int checks = 0;
  int errors = 0;
  int launches = 0;
  logic [31:0] exp_r[$];
  logic exp_z[$];
  logic [31:0] ma = '0, mb = '0;
  int cnt = 0;

  always #5 clk = ~clk;

  div_frontend #(.CACHE_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .ready(ready), .result(result), .div_zero(div_zero),
    .div_valid(div_valid), .div_op(div_op), .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_result(div_result)
  );

  // divider model: div_ready arrives 34 cycles after the div_valid cycle
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cnt <= 0;
    else if (div_valid) begin
      cnt <= 34;
      ma  <= div_a;
      mb  <= div_b;
    end else if (cnt != 0) cnt <= cnt - 1;
  end
  assign div_ready = cnt == 1;
  assign div_result = (mb == 0) ? (div_op[1] ? ma : 32'hFFFF_FFFF)
                    : div_op[0] ? (div_op[1] ? ma % mb : ma / mb)
                    : (div_op[1] ? $unsigned($signed(ma) % $signed(mb))
                                 : $unsigned($signed(ma) / $signed(mb)));

  always @(posedge clk) if (div_valid) launches++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ez, input int elat, input int elaunch);
    int n;
    int l0;
    @(negedge clk);
    valid = 1'b1; op = o; rs1 = a; rs2 = b;
    exp_r.push_back(er);
    exp_z.push_back(ez);
    l0 = launches;
    @(posedge clk);
    #1 valid = 1'b0; rs1 = $urandom; rs2 = $urandom;
    n = 1;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tag, "_result"}, result, exp_r.pop_front());
    chk({tag, "_zero"}, {31'd0, div_zero}, {31'd0, exp_z.pop_front()});
    chk({tag, "_latency"}, n, elat);
    chk({tag, "_launches"}, launches - l0, elaunch);
    @(posedge clk);
  endtask

  initial begin
    int n;
    int rdy;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_div_valid", {31'd0, div_valid}, 32'd0);
    chk("rst_div_op", {30'd0, div_op}, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    run("divu_100_7", `DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 37, 1);
    run("remu_hit", `DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1, 0);
    run("div_neg", `DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 37, 1);
    run("rem_hit", `DIV_OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 0);
    run("remu_miss", `DIV_OP_REMU, 32'hFFFF_FF9C, 32'd7, 32'd2, 1'b0, 37, 1);
    run("div_by0", `DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 0);
    run("rem_by0", `DIV_OP_REM, 32'd5, 32'd0, 32'd5, 1'b1, 1, 0);
    run("div_ovf", `DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 0);
    run("rem_ovf", `DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 0);
    run("divu_big", `DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 37, 1);

    // flush together with valid in IDLE: nothing accepted
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; op = `DIV_OP_DIV; rs1 = 32'd5; rs2 = 32'd0;
    @(posedge clk);
    #1 valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_noready", {31'd0, ready}, 32'd0);

    // flush while waiting on the divider
    @(negedge clk);
    valid = 1'b1; op = `DIV_OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    n = 0; rdy = 0;
    @(negedge clk);
    while (!div_ready && n < 100) begin
      rdy += int'(ready);
      @(negedge clk);
      n++;
    end
    chk("flush_drain_seen", {31'd0, div_ready}, 32'd1);
    @(negedge clk);
    rdy += int'(ready);
    chk("flush_no_ready", rdy, 0);
    run("after_flush_miss", `DIV_OP_REMU, 32'hFFFF_FF9C, 32'd7, 32'd2, 1'b0, 37, 1);
    run("relaunch_1000_3", `DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, 37, 1);

    // reset in the middle of a divide
    @(negedge clk);
    valid = 1'b1; op = `DIV_OP_DIVU; rs1 = 32'd77; rs2 = 32'd5;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_div_valid", {31'd0, div_valid}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    run("post_rst_9_2", `DIV_OP_DIVU, 32'd9, 32'd2, 32'd4, 1'b0, 37, 1);
    run("post_rst_rem_hit", `DIV_OP_REMU, 32'd9, 32'd2, 32'd1, 1'b0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
